// File: rtl/tick_bcd_display.sv
// Two-digit BCD tick counter fed by the square-wave bit of a divider, with a
// time-multiplexed active-low 7-segment display driver.
module tick_bcd_display #(
    parameter int REFRESH_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [3:0] compIn,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic       rollover,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

    logic          prev;
    logic          tick;
    logic [CW-1:0] refresh_cnt;
    logic          sel;
    logic [3:0]    shown_digit;
    logic [2:0]    phase_unused;

    // Only the square-wave bit matters; the divider phase bits are not used.
    assign phase_unused = compIn[2:0];
    assign tick         = compIn[3] & ~prev;

    always_ff @(posedge Clock) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= compIn[3];
        end
    end

    // Counter priority is reset, then clear, then an enabled tick.
    always_ff @(posedge Clock) begin
        if (reset || clear) begin
            bcd_ones <= 4'd0;
            bcd_tens <= 4'd0;
            rollover <= 1'b0;
        end else if (tick && enable) begin
            if (bcd_ones == 4'd9) begin
                bcd_ones <= 4'd0;
                if (bcd_tens == 4'd9) begin
                    bcd_tens <= 4'd0;
                    rollover <= 1'b1;
                end else begin
                    bcd_tens <= bcd_tens + 4'd1;
                    rollover <= 1'b0;
                end
            end else begin
                bcd_ones <= bcd_ones + 4'd1;
                rollover <= 1'b0;
            end
        end else begin
            rollover <= 1'b0;
        end
    end

    // Free-running scan timer; independent of counting, enable and clear.
    always_ff @(posedge Clock) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            sel         <= ~sel;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    assign shown_digit = sel ? bcd_tens : bcd_ones;
    assign an          = sel ? 2'b01 : 2'b10;

    // Segment order is {g,f,e,d,c,b,a}, low = lit; non-BCD values blank.
    always_comb begin
        seg = 7'b1111111;
        case (shown_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_tick_bcd_display.sv
// Directed self-checking bench for tick_bcd_display: counting, carry, wrap,
// enable/clear/reset interaction and display scanning.
module tb_tick_bcd_display;

    localparam int REFRESH = 4;

    logic       Clock = 1'b0;
    logic       reset;
    logic [3:0] compIn;
    logic       enable;
    logic       clear;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic       rollover;
    logic [6:0] seg;
    logic [1:0] an;

    int   checkCount = 0;
    int   failCount  = 0;
    int   expCount   = 0;
    int   sinceReset = 0;
    logic expRoll    = 1'b0;

    tick_bcd_display #(.REFRESH_CYCLES(REFRESH)) dut (
        .Clock    (Clock),
        .reset    (reset),
        .compIn   (compIn),
        .enable   (enable),
        .clear    (clear),
        .bcd_ones (bcd_ones),
        .bcd_tens (bcd_tens),
        .rollover (rollover),
        .seg      (seg),
        .an       (an)
    );

    always #5 Clock = ~Clock;

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic rst, input logic clr, input logic en, input logic bit3);
        reset  = rst;
        clear  = clr;
        enable = en;
        compIn = {bit3, 3'($urandom_range(7))};
        @(posedge Clock);
        #1;
        if (rst) sinceReset = 0;
        else     sinceReset++;
    endtask

    task automatic checkState(input string tag);
        int selExp;
        int digitExp;
        selExp   = (sinceReset / REFRESH) % 2;
        digitExp = (selExp == 1) ? (expCount / 10) : (expCount % 10);
        checkOutput({tag, "_ones"}, int'(bcd_ones), expCount % 10);
        checkOutput({tag, "_tens"}, int'(bcd_tens), expCount / 10);
        checkOutput({tag, "_rollover"}, int'(rollover), int'(expRoll));
        checkOutput({tag, "_an"}, int'(an), (selExp == 1) ? 1 : 2);
        checkOutput({tag, "_seg"}, int'(seg), int'(segOf(digitExp)));
    endtask

    task automatic countRise();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expCount = (expCount + 1) % 100;
        checkState("rise");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("fall");
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        enable = 1'b1;
        compIn = 4'b0000;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, (i % 2) == 0);
            checkState("reset_hold");
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("post_reset");

        for (int i = 0; i < 12; i++) countRise();
        checkOutput("twelve_bcd", int'({bcd_tens, bcd_ones}), 8'h12);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expCount = 13;
        checkState("long_high_rise");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            checkState("long_high_hold");
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("long_high_fall");

        while (expCount != 99) countRise();
        checkOutput("at_99_bcd", int'({bcd_tens, bcd_ones}), 8'h99);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expCount = 0;
        expRoll  = 1'b1;
        checkState("wrap");
        expRoll  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("wrap_after");

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkState("disabled_rise");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkState("disabled_fall");
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkState("enable_hold_low");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            checkState("enable_hold_high");
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("enable_hold_fall");
        countRise();
        checkOutput("first_after_enable", int'({bcd_tens, bcd_ones}), 8'h01);

        while (expCount != 47) countRise();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        expCount = 0;
        checkState("clear_with_tick");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkState("clear_tick_lost");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("clear_fall");

        while (expCount != 47) countRise();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        expCount = 0;
        checkState("reset_clear_tick");
        checkOutput("reset_an", int'(an), 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expCount = 1;
        checkState("high_after_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("high_after_reset_fall");

        while (expCount != 37) countRise();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkState("scan_37");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/tick_bcd_display.md
TICK_BCD_DISPLAY -- requirements
Module: tick_bcd_display

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 4, clock cycles per displayed digit (legal >= 2).
REQ-002 Port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: compIn  input  4  divider output; bit 3 = divided square wave, bits 2:0 = phase (ignored).
REQ-005 Port: enable  input  1  high = count ticks; low = ignore ticks.
REQ-006 Port: clear  input  1  synchronous count clear, active-high.
REQ-007 Port: bcd_ones  output  4  ones digit, registered, 0-9.
REQ-008 Port: bcd_tens  output  4  tens digit, registered, 0-9.
REQ-009 Port: rollover  output  1  registered one-cycle pulse on 99->00 wrap.
REQ-010 Port: seg  output  7  active-low segments {g,f,e,d,c,b,a}, bit 0 = a.
REQ-011 Port: an  output  2  active-low digit enables; an[0] = ones, an[1] = tens.

Function
REQ-012 Edge detect: register prev samples compIn[3] every cycle; tick = compIn[3] & ~prev.
REQ-013 Count latency: on an edge where tick=1 and enable=1, counter increments at that same edge, i.e. one cycle after compIn[3] rises.
REQ-014 Increment: ones 0-8 -> ones+1; ones 9 -> ones 0, tens+1; tens 9 & ones 9 -> 00.
REQ-015 rollover = 1 for exactly the cycle after the 99->00 edge, 0 otherwise.
REQ-016 enable=0: ticks discarded, never queued; prev keeps tracking compIn[3], so a level held high across enable rising produces no count.
REQ-017 Priority: reset > clear > tick increment.
REQ-018 clear=1: both digits -> 0, rollover -> 0; prev still updates; tick that edge is lost.
REQ-019 compIn[3] high for many cycles yields exactly one increment per rising transition.
REQ-020 Refresh: counter 0..REFRESH_CYCLES-1 free-runs; at terminal value wraps to 0 and digit select sel toggles.
REQ-021 sel=0: an=2'b10, seg shows bcd_ones; sel=1: an=2'b01, seg shows bcd_tens.
REQ-022 seg/an combinational from registered state only (no path from compIn).
REQ-023 Decoder (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 10-15 -> 1111111.
REQ-024 Display scanning unaffected by enable, clear, or ticks.

Reset
REQ-025 reset=1 at an edge: bcd_ones=0, bcd_tens=0, rollover=0, prev=0, refresh counter=0, sel=0.
REQ-026 During and after reset: an=2'b10, seg=1000000.
REQ-027 Reset mid-operation discards any tick in that cycle; first possible count is on the first edge with reset=0.
REQ-028 prev=0 after reset: compIn[3] already high at first non-reset edge counts as one tick (if enable=1).

Verification
REQ-029 reset held 3 cycles while compIn[3] toggles -> digits 00, rollover 0, an=10, seg=1000000 throughout.
REQ-030 enable=1, 12 rises of compIn[3] -> tens=1, ones=2; each increment exactly one cycle after the rise; 0->9->10 carry checked.
REQ-031 Drive to 99, one more rise -> 00 next edge; rollover high for exactly one cycle.
REQ-032 enable=0 across 3 rises -> no change; compIn[3] held high while enable 0->1 -> no count; next rise counts.
REQ-033 Count 47: clear coincident with tick -> 00; reset coincident with clear and tick -> 00, refresh/sel restart.
REQ-034 REFRESH_CYCLES=4, count 37 -> an=10, seg=1111000 for 4 cycles, then an=01, seg=0110000 for 4 cycles, repeating.
